delay_chain_len_ctrl: RTL and testbench

- Control block in front of RecfgDelayChain.
- Gates the chain's `en` from an upstream valid/ready stream.
- Accepts length-reconfiguration requests and applies them only in a cycle where the chain is not shifting. If no idle slot appears in time, it forces a one-cycle stall.
- Tracks fill state so downstream gets `out_valid` qualifying chain `dout` after flushes and length changes.

---
 rtl/delay_chain_len_ctrl.sv | 128 ++++++++++++
 tb/tb_delay_chain_len_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/delay_chain_len_ctrl.sv
// Length/enable controller for RecfgDelayChain: defers length changes to non-shifting cycles, tracks fill.
// Optional stats counters are enabled by defining DELAY_CHAIN_CTRL_STATS_EN.
module delay_chain_len_ctrl #(
    parameter int MAX_LEN  = 16,
    parameter int MIN_LEN  = 0,
    parameter int LW       = $clog2(MAX_LEN + 1),
    parameter int HOLD_MAX = 8,
    parameter int INIT_LEN = MAX_LEN
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          chain_en,
    output logic [LW-1:0] chain_length,
    input  logic          cfg_valid,
    input  logic [LW-1:0] cfg_len,
    output logic          cfg_ready,
    input  logic          flush,
    output logic          out_valid,
    output logic          cfg_clamped
`ifdef DELAY_CHAIN_CTRL_STATS_EN
    ,
    output logic [15:0]   stat_updates,
    output logic [15:0]   stat_stalls
`endif
);

    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    typedef enum logic [1:0] {RUN, PEND, STALL} state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] pend_len, fill_cnt, clamp_len, apply_len;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          cfg_oor, apply, load_pend, rdy, crdy;

    always_comb begin
        cfg_oor   = 1'b0;
        clamp_len = cfg_len;
        if (int'(cfg_len) > MAX_LEN) begin
            clamp_len = LW'(MAX_LEN);
            cfg_oor   = 1'b1;
        end else if (int'(cfg_len) < MIN_LEN) begin
            clamp_len = LW'(MIN_LEN);
            cfg_oor   = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        apply     = 1'b0;
        apply_len = pend_len;
        load_pend = 1'b0;
        rdy       = 1'b1;
        crdy      = 1'b0;
        case (state)
            RUN: begin
                crdy = 1'b1;
                if (cfg_valid) begin
                    if (in_valid) begin
                        load_pend = 1'b1;
                        hold_nxt  = '0;
                        state_nxt = PEND;
                    end else begin
                        apply     = 1'b1;
                        apply_len = clamp_len;
                    end
                end
            end
            PEND: begin
                if (!in_valid) begin
                    apply     = 1'b1;
                    state_nxt = RUN;
                end else if (hold_cnt == HW'(HOLD_MAX - 1)) begin
                    state_nxt = STALL;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            STALL: begin
                // Single forced bubble so the pending length lands on a non-shifting edge.
                rdy       = 1'b0;
                apply     = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign in_ready  = !rst_n || rdy;
    assign cfg_ready = !rst_n || crdy;
    assign chain_en  = in_valid && in_ready;
    assign out_valid = rst_n ? (fill_cnt >= chain_length) : (INIT_LEN == 0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            chain_length <= LW'(INIT_LEN);
            pend_len     <= '0;
            hold_cnt     <= '0;
            fill_cnt     <= '0;
            cfg_clamped  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            if (load_pend) pend_len <= clamp_len;
            if (apply) chain_length <= apply_len;
            if (state == RUN && cfg_valid && cfg_oor) cfg_clamped <= 1'b1;
            if (flush) fill_cnt <= '0;
            else if (chain_en && fill_cnt != LW'(MAX_LEN)) fill_cnt <= fill_cnt + 1'b1;
        end
    end

`ifdef DELAY_CHAIN_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_updates <= '0;
            stat_stalls  <= '0;
        end else begin
            if (apply) stat_updates <= stat_updates + 16'd1;
            if (state != STALL && state_nxt == STALL) stat_stalls <= stat_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_delay_chain_len_ctrl.sv
// Self-checking bench for delay_chain_len_ctrl: directed scenarios plus random traffic vs a behavioural model.
module tb_delay_chain_len_ctrl;

    localparam int MAX_LEN  = 16;
    localparam int LW       = 5;
    localparam int HOLD_MAX = 8;
    localparam int INIT_LEN = 16;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          in_valid = 1'b0, cfg_valid = 1'b0, flush = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic          in_ready, chain_en, cfg_ready, out_valid, cfg_clamped;
    logic [LW-1:0] chain_length;

    delay_chain_len_ctrl #(.MAX_LEN(MAX_LEN), .MIN_LEN(0), .LW(LW), .HOLD_MAX(HOLD_MAX),
                           .INIT_LEN(INIT_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .chain_en(chain_en), .chain_length(chain_length), .cfg_valid(cfg_valid),
        .cfg_len(cfg_len), .cfg_ready(cfg_ready), .flush(flush),
        .out_valid(out_valid), .cfg_clamped(cfg_clamped));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Model: current length, fill count, an optional pending length with its age, and a stall flag.
    int m_len = INIT_LEN, m_fill = 0, m_pend_len = 0, m_age = 0;
    bit m_pend = 0, m_stall = 0, m_clamped = 0;
    bit m_rdy, m_crdy, m_en, m_ov;

    task automatic drive(input bit iv, input bit cv, input int cl, input bit fl);
        in_valid  = iv;
        cfg_valid = cv;
        cfg_len   = cl[LW-1:0];
        flush     = fl;
        #1;
        if (!rst_n) begin
            m_rdy = 1; m_crdy = 1; m_ov = (INIT_LEN == 0);
        end else begin
            m_rdy  = !m_stall;
            m_crdy = !m_stall && !m_pend;
            m_ov   = m_fill >= m_len;
        end
        m_en = iv && m_rdy;
    endtask

    task automatic adv();
        int c;
        @(posedge clk);
        if (!rst_n) begin
            m_len = INIT_LEN; m_fill = 0; m_pend = 0; m_stall = 0; m_clamped = 0; m_age = 0;
        end else begin
            m_fill = flush ? 0 : ((m_fill + int'(m_en) > MAX_LEN) ? MAX_LEN : m_fill + int'(m_en));
            if (m_stall) begin
                m_len = m_pend_len; m_pend = 0; m_stall = 0;
            end else if (m_pend) begin
                m_age++;
                if (!in_valid) begin
                    m_len = m_pend_len; m_pend = 0;
                end else if (m_age >= HOLD_MAX) m_stall = 1;
            end else if (cfg_valid) begin
                c = int'(cfg_len);
                if (c > MAX_LEN) begin c = MAX_LEN; m_clamped = 1; end
                if (!in_valid) m_len = c;
                else begin m_pend = 1; m_pend_len = c; m_age = 0; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(0, 0, 0, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        adv(); adv();
        rst_n = 1;
        drive(0, 0, 0, 0);
        checks++; if (chain_length !== LW'(INIT_LEN)) begin errors++; $display("FAIL reset_len got=%0d exp=%0d", chain_length, INIT_LEN); end
        checks++; if (cfg_clamped !== 1'b0) begin errors++; $display("FAIL reset_clamped got=%b exp=0", cfg_clamped); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 0, 0);
            checks++; if (out_valid !== (k >= 16) || out_valid !== m_ov) begin errors++; $display("FAIL fill_out_valid k=%0d got=%b exp=%b", k, out_valid, k >= 16); end
            checks++; if (chain_length !== 5'd16) begin errors++; $display("FAIL fill_len k=%0d got=%0d exp=16", k, chain_length); end
            adv();
        end
    endtask

    task automatic test_idle_update();
        drive(0, 1, 4, 0);
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_cfg_ready got=%b exp=1", cfg_ready); end
        adv();
        drive(0, 0, 0, 0);
        checks++; if (chain_length !== 5'd4 || m_len != 4) begin errors++; $display("FAIL idle_len got=%0d exp=4", chain_length); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_forced_stall();
        drive(1, 1, 8, 0);
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL stall_accept got=%b exp=1", cfg_ready); end
        adv();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 0);
            checks++; if (in_ready !== (i != 8) || in_ready !== m_rdy) begin errors++; $display("FAIL stall_in_ready i=%0d got=%b exp=%b", i, in_ready, i != 8); end
            checks++; if (cfg_ready !== (i == 9)) begin errors++; $display("FAIL stall_cfg_ready i=%0d got=%b exp=%b", i, cfg_ready, i == 9); end
            checks++; if (chain_en !== (i != 8)) begin errors++; $display("FAIL stall_chain_en i=%0d got=%b exp=%b", i, chain_en, i != 8); end
            checks++; if (chain_length !== ((i <= 8) ? 5'd4 : 5'd8)) begin errors++; $display("FAIL stall_len i=%0d got=%0d", i, chain_length); end
            adv();
        end
    endtask

    task automatic test_grow_shrink();
        drive(0, 1, 4, 1);
        adv();
        for (int k = 0; k < 6; k++) begin drive(1, 0, 0, 0); adv(); end
        drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gs_fill6_len4 got=%b exp=1", out_valid); end
        drive(0, 1, 10, 0);
        adv();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0);
            checks++; if (out_valid !== 1'b0 || m_ov) begin errors++; $display("FAIL gs_grow k=%0d got=%b exp=0", k, out_valid); end
            adv();
        end
        drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gs_grow_done got=%b exp=1", out_valid); end
        drive(0, 1, 2, 0);
        adv();
        drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1 || chain_length !== 5'd2) begin errors++; $display("FAIL gs_shrink ov=%b len=%0d exp ov=1 len=2", out_valid, chain_length); end
    endtask

    task automatic test_clamp_flush();
        drive(0, 1, 20, 0);
        adv();
        drive(0, 0, 0, 0);
        checks++; if (chain_length !== 5'd16) begin errors++; $display("FAIL clamp_len got=%0d exp=16", chain_length); end
        checks++; if (cfg_clamped !== 1'b1) begin errors++; $display("FAIL clamp_flag got=%b exp=1", cfg_clamped); end
        drive(0, 1, 2, 0);
        adv();
        for (int k = 0; k < 3; k++) begin drive(1, 0, 0, 0); adv(); end
        drive(1, 0, 0, 1);
        checks++; if (out_valid !== 1'b1 || chain_en !== 1'b1) begin errors++; $display("FAIL flush_pre ov=%b en=%b exp 1 1", out_valid, chain_en); end
        adv();
        drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b0 || m_fill != 0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        checks++; if (cfg_clamped !== 1'b1) begin errors++; $display("FAIL clamp_sticky got=%b exp=1", cfg_clamped); end
    endtask

    task automatic test_reset_mid_pend();
        drive(1, 1, 3, 0);
        adv();
        drive(1, 0, 0, 0);
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rmp_pend got=%b exp=0", cfg_ready); end
        adv();
        rst_n = 0;
        drive(1, 0, 0, 0);
        adv();
        rst_n = 1;
        for (int i = 0; i < HOLD_MAX + 3; i++) begin
            drive(1, 0, 0, 0);
            checks++; if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin errors++; $display("FAIL rmp_run i=%0d rdy=%b crdy=%b exp 1 1", i, in_ready, cfg_ready); end
            checks++; if (chain_length !== LW'(INIT_LEN)) begin errors++; $display("FAIL rmp_len i=%0d got=%0d exp=%0d", i, chain_length, INIT_LEN); end
            adv();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 31)), $urandom_range(0, 15) == 0);
            checks++;
            if (in_ready !== m_rdy || cfg_ready !== m_crdy || chain_en !== m_en || out_valid !== m_ov ||
                chain_length !== LW'(m_len) || cfg_clamped !== m_clamped) begin
                errors++;
                $display("FAIL random n=%0d got rdy=%b crdy=%b en=%b ov=%b len=%0d clp=%b exp %b %b %b %b %0d %b",
                         n, in_ready, cfg_ready, chain_en, out_valid, chain_length, cfg_clamped,
                         m_rdy, m_crdy, m_en, m_ov, m_len, m_clamped);
            end
            adv();
        end
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_idle_update();
        test_forced_stall();
        test_grow_shrink();
        test_clamp_flush();
        test_reset_mid_pend();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
